axil_regbank: RTL and testbench

Parametrised AXI4-Lite slave register bank for the PAICORE datapath control plane: REG_NUM words of DATA_WIDTH bits, an upper read-only status region, byte-strobe writes, independent AW/W acceptance, and SLVERR/DECERR responses. It sits behind the host AXI-Lite interconnect and presents all read/write registers in parallel to datapath logic, with a per-write notification pulse.

---
 rtl/axil_regbank.sv | 225 ++++++++++++++++++++++
 tb/tb_axil_regbank.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_regbank.sv
// AXI4-Lite slave register bank: RW words exposed in parallel, read-only status words on top.
// Define AXIL_REGBANK_STRB_EN to honour wstrb byte lanes; otherwise every OKAY write replaces the whole word.
module axil_regbank #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int REG_NUM    = 1024,
    parameter int RO_NUM     = 0,
    localparam int IDX_W     = $clog2(REG_NUM),
    localparam int RW_NUM    = REG_NUM - RO_NUM,
    localparam int RO_W      = (RO_NUM > 0) ? RO_NUM : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_WIDTH-1:0]        s_axil_awaddr,
    input  logic [2:0]                   s_axil_awprot,
    input  logic                         s_axil_awvalid,
    output logic                         s_axil_awready,
    input  logic [DATA_WIDTH-1:0]        s_axil_wdata,
    input  logic [STRB_WIDTH-1:0]        s_axil_wstrb,
    input  logic                         s_axil_wvalid,
    output logic                         s_axil_wready,
    output logic [1:0]                   s_axil_bresp,
    output logic                         s_axil_bvalid,
    input  logic                         s_axil_bready,
    input  logic [ADDR_WIDTH-1:0]        s_axil_araddr,
    input  logic [2:0]                   s_axil_arprot,
    input  logic                         s_axil_arvalid,
    output logic                         s_axil_arready,
    output logic [DATA_WIDTH-1:0]        s_axil_rdata,
    output logic [1:0]                   s_axil_rresp,
    output logic                         s_axil_rvalid,
    input  logic                         s_axil_rready,
    output logic [RW_NUM*DATA_WIDTH-1:0] reg_q,
    input  logic [RO_W*DATA_WIDTH-1:0]   ro_in,
    output logic                         wr_pulse,
    output logic [IDX_W-1:0]             wr_index
);

    localparam int ADDR_LSB = $clog2(STRB_WIDTH);
    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(REG_NUM * STRB_WIDTH);
    localparam logic [IDX_W:0]      RW_LIMIT   = (IDX_W + 1)'(RW_NUM);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Write-side holding registers
    logic                    aw_full_q;
    logic [ADDR_WIDTH-1:0]   aw_addr_q;
    logic                    w_full_q;
    logic [DATA_WIDTH-1:0]   w_data_q;
`ifdef AXIL_REGBANK_STRB_EN
    logic [STRB_WIDTH-1:0]   w_strb_q;
`endif

    logic                    bvalid_q;
    logic [1:0]              bresp_q;
    logic                    wr_pulse_q;
    logic [IDX_W-1:0]        wr_index_q;

    logic                    rvalid_q;
    logic [1:0]              rresp_q;
    logic [DATA_WIDTH-1:0]   rdata_q;

    logic [RW_NUM*DATA_WIDTH-1:0] regs_flat;

    logic                    aw_hs;
    logic                    w_hs;
    logic                    ar_hs;
    logic                    commit;
    logic                    commit_ok;
    logic [IDX_W-1:0]        wr_idx;
    logic                    wr_decerr;
    logic                    wr_ro;
    logic [1:0]              wr_resp_d;

    logic [IDX_W-1:0]        rd_idx;
    logic                    rd_decerr;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [DATA_WIDTH-1:0]   rdata_d;
    logic [1:0]              rresp_d;

    // Protection bits and unused strobe/status bits carry no meaning here
    logic unused_bits;
    assign unused_bits = ^{s_axil_awprot, s_axil_arprot, s_axil_wstrb, ro_in};

    assign s_axil_awready = ~aw_full_q & ~rst;
    assign s_axil_wready  = ~w_full_q & ~rst;
    assign s_axil_arready = ~rvalid_q & ~rst;

    assign aw_hs = s_axil_awvalid & s_axil_awready;
    assign w_hs  = s_axil_wvalid & s_axil_wready;
    assign ar_hs = s_axil_arvalid & s_axil_arready;

    assign wr_idx    = aw_addr_q[ADDR_LSB +: IDX_W];
    assign wr_decerr = {1'b0, aw_addr_q} >= ADDR_LIMIT;
    assign wr_ro     = {1'b0, wr_idx} >= RW_LIMIT;
    assign wr_resp_d = wr_decerr ? RESP_DECERR : (wr_ro ? RESP_SLVERR : RESP_OKAY);

    // A completed pair may only commit once the previous response has left or is leaving
    assign commit    = aw_full_q & w_full_q & (~bvalid_q | s_axil_bready);
    assign commit_ok = commit & (wr_resp_d == RESP_OKAY);

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_full_q <= 1'b0;
            aw_addr_q <= '0;
        end else if (aw_hs) begin
            aw_full_q <= 1'b1;
            aw_addr_q <= s_axil_awaddr;
        end else if (commit) begin
            aw_full_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_full_q <= 1'b0;
            w_data_q <= '0;
`ifdef AXIL_REGBANK_STRB_EN
            w_strb_q <= '0;
`endif
        end else if (w_hs) begin
            w_full_q <= 1'b1;
            w_data_q <= s_axil_wdata;
`ifdef AXIL_REGBANK_STRB_EN
            w_strb_q <= s_axil_wstrb;
`endif
        end else if (commit) begin
            w_full_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= 1'b0;
            wr_index_q <= '0;
        end else begin
            wr_pulse_q <= commit_ok;
            if (commit_ok) begin
                wr_index_q <= wr_idx;
            end
            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_resp_d;
            end else if (s_axil_bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // One storage word per RW index, each with its own decoded write enable
    for (genvar gi = 0; gi < RW_NUM; gi++) begin : g_word
        logic [DATA_WIDTH-1:0] word_q;
        logic                  hit;

        assign hit = commit_ok && (wr_idx == IDX_W'(gi));

        always_ff @(posedge clk) begin
            if (rst) begin
                word_q <= '0;
            end else if (hit) begin
`ifdef AXIL_REGBANK_STRB_EN
                for (int b = 0; b < STRB_WIDTH; b++) begin
                    if (w_strb_q[b]) begin
                        word_q[b*8 +: 8] <= w_data_q[b*8 +: 8];
                    end
                end
`else
                word_q <= w_data_q;
`endif
            end
        end

        assign regs_flat[gi*DATA_WIDTH +: DATA_WIDTH] = word_q;
    end

    assign reg_q = regs_flat;

    // Read decode uses the current register contents, so a same-edge commit is not visible
    assign rd_idx    = s_axil_araddr[ADDR_LSB +: IDX_W];
    assign rd_decerr = {1'b0, s_axil_araddr} >= ADDR_LIMIT;

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < RW_NUM; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_word = regs_flat[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        for (int j = 0; j < RO_NUM; j++) begin
            if (rd_idx == IDX_W'(RW_NUM + j)) begin
                rd_word = ro_in[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign rdata_d = rd_decerr ? '0 : rd_word;
    assign rresp_d = rd_decerr ? RESP_DECERR : RESP_OKAY;

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rresp_q  <= rresp_d;
            rdata_q  <= rdata_d;
        end else if (s_axil_rready) begin
            rvalid_q <= 1'b0;
        end
    end

    assign s_axil_bvalid = bvalid_q;
    assign s_axil_bresp  = bresp_q;
    assign s_axil_rvalid = rvalid_q;
    assign s_axil_rresp  = rresp_q;
    assign s_axil_rdata  = rdata_q;
    assign wr_pulse      = wr_pulse_q;
    assign wr_index      = wr_index_q;

endmodule

// File: tb/tb_axil_regbank.sv
// Directed bench for axil_regbank (64-bit words, 16 words, top 4 read-only).
`timescale 1ns/1ps
module tb_axil_regbank;

    localparam int DW  = 64;
    localparam int AW  = 32;
    localparam int SW  = 8;
    localparam int RN  = 16;
    localparam int RON = 4;
    localparam int RWN = RN - RON;
    localparam int IW  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0] s_axil_awaddr = '0;
    logic [2:0] s_axil_awprot = '0;
    logic s_axil_awvalid = 1'b0;
    logic s_axil_awready;
    logic [DW-1:0] s_axil_wdata = '0;
    logic [SW-1:0] s_axil_wstrb = '0;
    logic s_axil_wvalid = 1'b0;
    logic s_axil_wready;
    logic [1:0] s_axil_bresp;
    logic s_axil_bvalid;
    logic s_axil_bready = 1'b0;
    logic [AW-1:0] s_axil_araddr = '0;
    logic [2:0] s_axil_arprot = '0;
    logic s_axil_arvalid = 1'b0;
    logic s_axil_arready;
    logic [DW-1:0] s_axil_rdata;
    logic [1:0] s_axil_rresp;
    logic s_axil_rvalid;
    logic s_axil_rready = 1'b0;
    logic [RWN*DW-1:0] reg_q;
    logic [RON*DW-1:0] ro_in = '0;
    logic wr_pulse;
    logic [IW-1:0] wr_index;

    int checks = 0;
    int failures = 0;
    int pulse_cnt = 0;
    logic [IW-1:0] last_idx = '0;

    axil_regbank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_NUM(RN), .RO_NUM(RON)) dut (
        .clk(clk), .rst(rst),
        .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
        .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
        .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
        .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
        .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
        .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
        .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
        .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
        .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
        .reg_q(reg_q), .ro_in(ro_in), .wr_pulse(wr_pulse), .wr_index(wr_index)
    );

    always @(negedge clk) begin
        if (wr_pulse === 1'b1) begin
            pulse_cnt++;
            last_idx = wr_index;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                            output logic [1:0] resp, output bit ok);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        int n = 0;
        ok = 0;
        resp = 2'b01;
        s_axil_awaddr = a; s_axil_wdata = d; s_axil_wstrb = s;
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
        while (!(aw_done && w_done) && n < 20) begin
            aw_hs = s_axil_awvalid && s_axil_awready;
            w_hs = s_axil_wvalid && s_axil_wready;
            step(); n++;
            if (aw_hs) begin s_axil_awvalid = 1'b0; aw_done = 1; end
            if (w_hs) begin s_axil_wvalid = 1'b0; w_done = 1; end
        end
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        s_axil_bready = 1'b1; n = 0;
        while (!s_axil_bvalid && n < 20) begin step(); n++; end
        if (s_axil_bvalid) begin resp = s_axil_bresp; ok = aw_done && w_done; end
        step();
        s_axil_bready = 1'b0;
        $display("WR addr=%h data=%h strb=%h resp=%0d ok=%0d", a, d, s, resp, ok);
    endtask

    task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic [1:0] resp,
                           output bit ok);
        bit hs = 0;
        int n = 0;
        ok = 0; d = '1; resp = 2'b01;
        s_axil_araddr = a; s_axil_arvalid = 1'b1;
        while (!hs && n < 20) begin hs = s_axil_arready; step(); n++; end
        s_axil_arvalid = 1'b0;
        s_axil_rready = 1'b1; n = 0;
        while (!s_axil_rvalid && n < 20) begin step(); n++; end
        if (s_axil_rvalid) begin d = s_axil_rdata; resp = s_axil_rresp; ok = hs; end
        step();
        s_axil_rready = 1'b0;
        $display("RD addr=%h data=%h resp=%0d ok=%0d", a, d, resp, ok);
    endtask

    task automatic test_reset();
        repeat (3) step();
        checks++; if ({s_axil_awready, s_axil_wready, s_axil_arready} !== 3'b000) begin failures++; $display("FAIL reset_ready got=%b want=000", {s_axil_awready, s_axil_wready, s_axil_arready}); end
        checks++; if ({s_axil_bvalid, s_axil_rvalid, wr_pulse} !== 3'b000) begin failures++; $display("FAIL reset_valid got=%b want=000", {s_axil_bvalid, s_axil_rvalid, wr_pulse}); end
        checks++; if (reg_q !== '0) begin failures++; $display("FAIL reset_regs got=%h want=0", reg_q); end
        rst = 1'b0;
        #1;
        checks++; if ({s_axil_awready, s_axil_wready, s_axil_arready} !== 3'b111) begin failures++; $display("FAIL release_ready got=%b want=111", {s_axil_awready, s_axil_wready, s_axil_arready}); end
    endtask

    task automatic test_write_read();
        logic [1:0] resp; logic [DW-1:0] d; bit ok; int p0 = pulse_cnt;
        do_write(32'h18, 64'h1122334455667788, 8'hFF, resp, ok);
        checks++; if (!ok || resp !== 2'b00) begin failures++; $display("FAIL wr3_bresp got=%0d ok=%0d want=0", resp, ok); end
        checks++; if (reg_q[3*DW +: DW] !== 64'h1122334455667788) begin failures++; $display("FAIL wr3_reg got=%h want=1122334455667788", reg_q[3*DW +: DW]); end
        checks++; if (pulse_cnt - p0 !== 1 || last_idx !== 4'd3) begin failures++; $display("FAIL wr3_pulse got=%0d idx=%0d want=1 idx=3", pulse_cnt - p0, last_idx); end
        do_read(32'h18, d, resp, ok);
        checks++; if (!ok || resp !== 2'b00 || d !== 64'h1122334455667788) begin failures++; $display("FAIL rd3 got=%h resp=%0d want=1122334455667788 resp=0", d, resp); end
        do_read(32'h1B, d, resp, ok);
        checks++; if (!ok || resp !== 2'b00 || d !== 64'h1122334455667788) begin failures++; $display("FAIL rd3_unaligned got=%h resp=%0d want=1122334455667788", d, resp); end
    endtask

    task automatic test_strobe();
        logic [1:0] resp; logic [DW-1:0] d, exp; bit ok; int p0 = pulse_cnt;
`ifdef AXIL_REGBANK_STRB_EN
        exp = 64'hFFFF_FFFF_0000_0000;
`else
        exp = 64'h0;
`endif
        do_write(32'h28, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, resp, ok);
        do_write(32'h28, 64'h0, 8'h0F, resp, ok);
        checks++; if (!ok || resp !== 2'b00) begin failures++; $display("FAIL strb_bresp got=%0d want=0", resp); end
        do_read(32'h28, d, resp, ok);
        checks++; if (d !== exp) begin failures++; $display("FAIL strb_data got=%h want=%h", d, exp); end
        checks++; if (pulse_cnt - p0 !== 2 || last_idx !== 4'd5) begin failures++; $display("FAIL strb_pulse got=%0d idx=%0d want=2 idx=5", pulse_cnt - p0, last_idx); end
    endtask

    task automatic test_timing();
        logic [DW-1:0] v = 64'h6666_5555_4444_3333;
        s_axil_awaddr = 32'h30; s_axil_wdata = v; s_axil_wstrb = 8'hFF;
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1; s_axil_bready = 1'b1;
        step();
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        checks++; if (s_axil_bvalid !== 1'b0 || wr_pulse !== 1'b0) begin failures++; $display("FAIL tim_early got bvalid=%b pulse=%b want=0 0", s_axil_bvalid, wr_pulse); end
        step();
        checks++; if (s_axil_bvalid !== 1'b1 || wr_pulse !== 1'b1 || wr_index !== 4'd6) begin failures++; $display("FAIL tim_commit got bvalid=%b pulse=%b idx=%0d want=1 1 6", s_axil_bvalid, wr_pulse, wr_index); end
        checks++; if (reg_q[6*DW +: DW] !== v) begin failures++; $display("FAIL tim_reg got=%h want=%h", reg_q[6*DW +: DW], v); end
        step();
        s_axil_bready = 1'b0;
        checks++; if (s_axil_bvalid !== 1'b0 || wr_pulse !== 1'b0 || s_axil_awready !== 1'b1) begin failures++; $display("FAIL tim_after got bvalid=%b pulse=%b awready=%b want=0 0 1", s_axil_bvalid, wr_pulse, s_axil_awready); end
        s_axil_araddr = 32'h30; s_axil_arvalid = 1'b1; s_axil_rready = 1'b1;
        step();
        s_axil_arvalid = 1'b0;
        checks++; if (s_axil_rvalid !== 1'b1 || s_axil_rdata !== v || s_axil_arready !== 1'b0) begin failures++; $display("FAIL tim_read got rvalid=%b data=%h arready=%b want=1 %h 0", s_axil_rvalid, s_axil_rdata, s_axil_arready, v); end
        step();
        s_axil_rready = 1'b0;
        checks++; if (s_axil_rvalid !== 1'b0 || s_axil_arready !== 1'b1) begin failures++; $display("FAIL tim_rdone got rvalid=%b arready=%b want=0 1", s_axil_rvalid, s_axil_arready); end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] va = 64'h0707_0707_0707_0707, vb = 64'hA5A5_0000_5A5A_1234;
        int p0 = pulse_cnt;
        s_axil_bready = 1'b0;
        s_axil_wdata = va; s_axil_wstrb = 8'hFF; s_axil_wvalid = 1'b1;
        step();
        s_axil_wvalid = 1'b0;
        step(); step();
        checks++; if (s_axil_wready !== 1'b0 || s_axil_bvalid !== 1'b0) begin failures++; $display("FAIL bp_wonly got wready=%b bvalid=%b want=0 0", s_axil_wready, s_axil_bvalid); end
        s_axil_awaddr = 32'h38; s_axil_awvalid = 1'b1;
        step();
        s_axil_awvalid = 1'b0;
        step();
        checks++; if (s_axil_bvalid !== 1'b1 || s_axil_bresp !== 2'b00 || reg_q[7*DW +: DW] !== va) begin failures++; $display("FAIL bp_first got bvalid=%b resp=%0d reg=%h want=1 0 %h", s_axil_bvalid, s_axil_bresp, reg_q[7*DW +: DW], va); end
        s_axil_wdata = vb; s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
        step();
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (s_axil_bvalid !== 1'b1 || s_axil_bresp !== 2'b00 || reg_q[7*DW +: DW] !== va || s_axil_awready !== 1'b0) begin failures++; $display("FAIL bp_hold%0d got bvalid=%b resp=%0d reg=%h awready=%b want=1 0 %h 0", i, s_axil_bvalid, s_axil_bresp, reg_q[7*DW +: DW], s_axil_awready, va); end
        end
        checks++; if (pulse_cnt - p0 !== 1) begin failures++; $display("FAIL bp_pulse1 got=%0d want=1", pulse_cnt - p0); end
        s_axil_bready = 1'b1;
        step();
        checks++; if (s_axil_bvalid !== 1'b1 || reg_q[7*DW +: DW] !== vb) begin failures++; $display("FAIL bp_second got bvalid=%b reg=%h want=1 %h", s_axil_bvalid, reg_q[7*DW +: DW], vb); end
        step();
        s_axil_bready = 1'b0;
        checks++; if (s_axil_bvalid !== 1'b0 || pulse_cnt - p0 !== 2) begin failures++; $display("FAIL bp_done got bvalid=%b pulses=%0d want=0 2", s_axil_bvalid, pulse_cnt - p0); end
    endtask

    task automatic test_readonly();
        logic [1:0] resp; logic [DW-1:0] d; bit ok; int p0 = pulse_cnt;
        logic [RWN*DW-1:0] snap = reg_q;
        do_write(32'h70, 64'hDEAD_BEEF, 8'hFF, resp, ok);
        checks++; if (!ok || resp !== 2'b10) begin failures++; $display("FAIL ro_wr_resp got=%0d want=2", resp); end
        checks++; if (reg_q !== snap || pulse_cnt != p0) begin failures++; $display("FAIL ro_wr_effect pulses=%0d want=0 regs_changed=%0d", pulse_cnt - p0, reg_q !== snap); end
        do_read(32'h70, d, resp, ok);
        checks++; if (!ok || resp !== 2'b00 || d !== 64'hABCD) begin failures++; $display("FAIL ro_rd14 got=%h resp=%0d want=abcd 0", d, resp); end
        do_read(32'h60, d, resp, ok);
        checks++; if (resp !== 2'b00 || d !== 64'h1111) begin failures++; $display("FAIL ro_rd12 got=%h resp=%0d want=1111 0", d, resp); end
        do_read(32'h78, d, resp, ok);
        checks++; if (resp !== 2'b00 || d !== 64'hF0F0) begin failures++; $display("FAIL ro_rd15 got=%h resp=%0d want=f0f0 0", d, resp); end
    endtask

    task automatic test_decerr();
        logic [1:0] resp; logic [DW-1:0] d; bit ok; int p0 = pulse_cnt;
        logic [RWN*DW-1:0] snap = reg_q;
        do_write(32'h80, 64'h1234, 8'hFF, resp, ok);
        checks++; if (!ok || resp !== 2'b11) begin failures++; $display("FAIL dec_wr_resp got=%0d want=3", resp); end
        do_write(32'h1000_0018, 64'h5678, 8'hFF, resp, ok);
        checks++; if (resp !== 2'b11) begin failures++; $display("FAIL dec_wr_high got=%0d want=3", resp); end
        checks++; if (reg_q !== snap || pulse_cnt != p0) begin failures++; $display("FAIL dec_wr_effect pulses=%0d want=0 regs_changed=%0d", pulse_cnt - p0, reg_q !== snap); end
        do_read(32'h80, d, resp, ok);
        checks++; if (!ok || resp !== 2'b11 || d !== 64'h0) begin failures++; $display("FAIL dec_rd got=%h resp=%0d want=0 3", d, resp); end
        do_read(32'h1000_0018, d, resp, ok);
        checks++; if (resp !== 2'b11 || d !== 64'h0) begin failures++; $display("FAIL dec_rd_high got=%h resp=%0d want=0 3", d, resp); end
    endtask

    task automatic test_same_edge();
        logic [1:0] resp; logic [DW-1:0] d; bit ok;
        logic [DW-1:0] x = 64'h4444_0000_4444_0001, y = 64'h9999_8888_7777_6666;
        do_write(32'h20, x, 8'hFF, resp, ok);
        s_axil_awaddr = 32'h20; s_axil_wdata = y; s_axil_wstrb = 8'hFF;
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
        step();
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        s_axil_araddr = 32'h20; s_axil_arvalid = 1'b1; s_axil_bready = 1'b1;
        step();
        s_axil_arvalid = 1'b0;
        checks++; if (s_axil_rvalid !== 1'b1 || s_axil_rdata !== x) begin failures++; $display("FAIL same_edge_old got rvalid=%b data=%h want=1 %h", s_axil_rvalid, s_axil_rdata, x); end
        checks++; if (reg_q[4*DW +: DW] !== y) begin failures++; $display("FAIL same_edge_reg got=%h want=%h", reg_q[4*DW +: DW], y); end
        s_axil_rready = 1'b1;
        step();
        s_axil_rready = 1'b0; s_axil_bready = 1'b0;
        do_read(32'h20, d, resp, ok);
        checks++; if (!ok || d !== y) begin failures++; $display("FAIL same_edge_new got=%h want=%h", d, y); end
    endtask

    task automatic test_reset_midway();
        int p0 = pulse_cnt;
        s_axil_awaddr = 32'h10; s_axil_awvalid = 1'b1;
        step();
        s_axil_awvalid = 1'b0;
        rst = 1'b1;
        step();
        checks++; if ({s_axil_awready, s_axil_wready, s_axil_arready} !== 3'b000 || reg_q !== '0) begin failures++; $display("FAIL mid_rst got ready=%b regs_nonzero=%0d want=000 0", {s_axil_awready, s_axil_wready, s_axil_arready}, reg_q !== '0); end
        rst = 1'b0;
        s_axil_wdata = 64'h5; s_axil_wstrb = 8'hFF; s_axil_wvalid = 1'b1;
        step();
        s_axil_wvalid = 1'b0; s_axil_bready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (s_axil_bvalid !== 1'b0) begin failures++; $display("FAIL mid_bvalid%0d got=%b want=0", i, s_axil_bvalid); end
        end
        s_axil_bready = 1'b0;
        checks++; if (reg_q !== '0 || pulse_cnt != p0) begin failures++; $display("FAIL mid_after regs_nonzero=%0d pulses=%0d want=0 0", reg_q !== '0, pulse_cnt - p0); end
    endtask

    initial begin
        ro_in[0*DW +: DW] = 64'h1111;
        ro_in[2*DW +: DW] = 64'hABCD;
        ro_in[3*DW +: DW] = 64'hF0F0;
        test_reset();
        test_write_read();
        test_strobe();
        test_timing();
        test_backpressure();
        test_readonly();
        test_decerr();
        test_same_edge();
        test_reset_midway();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
